alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have one clock domain; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  block can accept a command; high only in IDLE.
REQ-006 cmd_load  in  1  1 = load immediate, 0 = ALU operation.
REQ-007 cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOR, 111 SLT.
REQ-008 cmd_rd / cmd_rs1 / cmd_rs2  in  2 each  destination and source register indices.
REQ-009 cmd_imm  in  4  immediate for load.
REQ-010 alu_a / alu_b  out  4 each  registered operands to the external combinational ALU.
REQ-011 alu_opcode  out  3  registered opcode to the ALU.
REQ-012 alu_result  in  4  ALU result; alu_carry  in  1  carry/borrow; alu_zero  in  1  zero flag.
REQ-013 rsp_valid  out  1  response present; rsp_ready  in  1  response consumed.
REQ-014 rsp_data  out  4  result; rsp_carry  out  1; rsp_zero  out  1.
REQ-015 ops_done  out  8  count of completed responses.

Function
REQ-016 The block SHALL contain a register file of four 4-bit registers, r0 to r3, and none is hardwired.
REQ-017 The FSM SHALL have three states:
- IDLE -> EXEC on cmd_valid && cmd_ready.
- EXEC -> RESP unconditionally after 1 cycle.
- RESP -> IDLE on rsp_valid && rsp_ready.
REQ-018 On acceptance, the block SHALL capture the command. For an ALU operation, it SHALL also load alu_a = r[rs1], alu_b = r[rs2] and alu_opcode = cmd_op, reading the register values as they stand at the accept edge.
REQ-019 In EXEC, the block SHALL sample alu_result, alu_carry and alu_zero at the closing edge. It SHALL write alu_result to r[rd] and latch rsp_data, rsp_carry and rsp_zero.
REQ-020 In EXEC for a load, the block SHALL write cmd_imm to r[rd] and set rsp_data = imm, rsp_carry = 0 and rsp_zero = (imm == 0). alu_a, alu_b and alu_opcode SHALL keep their prior values.
REQ-021 Latency: for a command accepted at edge N, rsp_valid SHALL be high from edge N+2.
REQ-022 While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_carry and rsp_zero SHALL stay stable. cmd_ready SHALL stay 0 and no new command SHALL be accepted.
REQ-023 The block SHALL hold at most one command in flight; it SHALL ignore cmd_valid outside IDLE.
REQ-024 The same index SHALL be allowed for rd, rs1 and rs2. Operands SHALL be the pre-write values, and the write SHALL take effect for the next command.
REQ-025 ops_done SHALL increment on each rsp handshake and wrap from 255 to 0.
REQ-026 The block SHALL pass flags from the ALU unchanged. SUB borrow appears as carry, SLT carry is 0, and no flag is recomputed except for loads.
REQ-027 alu_a, alu_b and alu_opcode SHALL change only on an accept edge.

Reset
REQ-028 With rst high at a rising edge, the block SHALL set state = IDLE, r0 to r3 = 0, alu_a = alu_b = 0, alu_opcode = 000, rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_zero = 0 and ops_done = 0.
REQ-029 After that edge, cmd_ready SHALL be 1. Reset SHALL take priority over every other event.
REQ-030 Reset in EXEC or RESP SHALL abort the command. The register-file write, the response and the ops_done increment SHALL all be discarded.

Verification
REQ-031 The bench SHALL drive the block against the team's 4-bit ALU and SHALL cover these scenarios:
- Load r1=9 and r2=8, then ADD r3=r1+r2 -> rsp_data=1, carry=1, zero=0 at accept+2; ops_done=3.
- SUB r0=r2-r1 (8-9) -> rsp_data=0xF, carry=1, zero=0. Then SLT r3=r2<r1 -> rsp_data=1, carry=0.
- Hold rsp_ready low 5 cycles, with cmd_valid high throughout -> rsp fields stable, cmd_ready=0, second command accepted only the cycle after the handshake.
- Assert rst in EXEC, then ADD r0=r1+r2 -> rsp_data=0, zero=1, ops_done=1.
- Load r1=3, then ADD r1=r1+r1 -> 6, then ADD r2=r1+r0 -> 6.
- Complete 256 responses -> ops_done returns to 0. Load of 0 -> zero=1, carry=0.

Source files
------------

// File: rtl/alu_ctrl.sv
// Sequencer that feeds an external 4-bit combinational ALU from a four-entry register file.
// Commands are accepted one at a time and answered through a valid/ready response port.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cmdAccept, rspFire;

  logic [3:0]  regFile_q [4];
  logic [3:0]  regFile_d [4];
  logic [3:0]  aluA_q, aluA_d;
  logic [3:0]  aluB_q, aluB_d;
  logic [2:0]  aluOp_q, aluOp_d;
  logic        isLoad_q, isLoad_d;
  logic [1:0]  rd_q, rd_d;
  logic [3:0]  imm_q, imm_d;
  logic [3:0]  rspData_q, rspData_d;
  logic        rspCarry_q, rspCarry_d;
  logic        rspZero_q, rspZero_d;
  logic [7:0]  opsDone_q, opsDone_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    cmdAccept = cmd_valid && cmd_ready;
    rspFire   = rsp_valid && rsp_ready;
  end

  // Operands are read from the register file as it stands at the accept edge,
  // so a command whose rd matches rs1/rs2 always sees the pre-write value.
  always_comb begin
    regFile_d  = regFile_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluOp_d    = aluOp_q;
    isLoad_d   = isLoad_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    rspData_d  = rspData_q;
    rspCarry_d = rspCarry_q;
    rspZero_d  = rspZero_q;
    opsDone_d  = opsDone_q;

    if (cmdAccept) begin
      isLoad_d = cmd_load;
      rd_d     = cmd_rd;
      imm_d    = cmd_imm;
      if (!cmd_load) begin
        aluA_d  = regFile_q[cmd_rs1];
        aluB_d  = regFile_q[cmd_rs2];
        aluOp_d = cmd_op;
      end
    end

    if (state_q == EXEC) begin
      if (isLoad_q) begin
        regFile_d[rd_q] = imm_q;
        rspData_d       = imm_q;
        rspCarry_d      = 1'b0;
        rspZero_d       = (imm_q == 4'd0);
      end else begin
        regFile_d[rd_q] = alu_result;
        rspData_d       = alu_result;
        rspCarry_d      = alu_carry;
        rspZero_d       = alu_zero;
      end
    end

    if (rspFire) begin
      opsDone_d = opsDone_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regFile_q[i] <= 4'd0;
      end
      aluA_q     <= 4'd0;
      aluB_q     <= 4'd0;
      aluOp_q    <= 3'd0;
      isLoad_q   <= 1'b0;
      rd_q       <= 2'd0;
      imm_q      <= 4'd0;
      rspData_q  <= 4'd0;
      rspCarry_q <= 1'b0;
      rspZero_q  <= 1'b0;
      opsDone_q  <= 8'd0;
    end else begin
      regFile_q  <= regFile_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluOp_q    <= aluOp_d;
      isLoad_q   <= isLoad_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      rspData_q  <= rspData_d;
      rspCarry_q <= rspCarry_d;
      rspZero_q  <= rspZero_d;
      opsDone_q  <= opsDone_d;
    end
  end

  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_opcode = aluOp_q;
  assign rsp_data   = rspData_q;
  assign rsp_carry  = rspCarry_q;
  assign rsp_zero   = rspZero_q;
  assign ops_done   = opsDone_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: stimulus pushes expected responses, a monitor pops and compares.
// A stand-in 4-bit ALU and a register-file model live here.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_result;
  logic       alu_carry, alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_carry, rsp_zero;
  logic [7:0] ops_done;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .ops_done   (ops_done)
  );

  // Arithmetic meaning of each opcode; returns {carry, result}.
  function automatic logic [4:0] aluRef(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int   ia, ib, r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 15); end
      3'd1: begin r = ia - ib; c = (ia < ib); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(4'(~(a & b)));
      3'd6: r = int'(4'(~(a | b)));
      default: r = (ia < ib) ? 1 : 0;
    endcase
    return {c, 4'(r)};
  endfunction

  always_comb begin
    logic [4:0] res;
    res        = aluRef(alu_a, alu_b, alu_opcode);
    alu_result = res[3:0];
    alu_carry  = res[4];
    alu_zero   = (res[3:0] == 4'd0);
  end

  typedef struct {
    logic [3:0] data;
    logic       carry;
    logic       zero;
    int         acceptCyc;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         opsDone = 0;
  logic [3:0] modelRf [4];
  logic [3:0] expAluA, expAluB;
  logic [2:0] expAluOp;
  bit         monitorOn = 0;
  bit         frontSeen = 0;
  bit         randomReady = 0;
  logic       readyLevel = 1'b1;
  logic [3:0] lastData;
  logic       lastCarry, lastZero;
  int         lastHsCyc = 0;
  int         lastAcceptCyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Response-side ready, changed just after the rising edge.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = randomReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end
  end

  // Monitor: compares outputs against the scoreboard head while a response is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (monitorOn) begin
        checkOutput("alu_a", int'(alu_a), int'(expAluA));
        checkOutput("alu_b", int'(alu_b), int'(expAluB));
        checkOutput("alu_opcode", int'(alu_opcode), int'(expAluOp));
        if (rsp_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 1, 0);
          end else begin
            if (!frontSeen) begin
              checkOutput("latency", cyc, expQ[0].acceptCyc + 1);
              frontSeen = 1;
            end
            checkOutput("rsp_data", int'(rsp_data), int'(expQ[0].data));
            checkOutput("rsp_carry", int'(rsp_carry), int'(expQ[0].carry));
            checkOutput("rsp_zero", int'(rsp_zero), int'(expQ[0].zero));
            checkOutput("cmd_ready_busy", int'(cmd_ready), 0);
            if (rsp_ready) begin
              checkOutput("ops_done", int'(ops_done), opsDone % 256);
              lastData  = rsp_data;
              lastCarry = rsp_carry;
              lastZero  = rsp_zero;
              lastHsCyc = cyc + 1;
              void'(expQ.pop_front());
              opsDone++;
              frontSeen = 0;
            end
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic applyStimulus(input bit load, input logic [2:0] op, input logic [1:0] rd,
                               input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm);
    exp_t       e;
    logic [4:0] r;
    int         waitCnt;
    cmd_valid = 1'b1;
    cmd_load  = load;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    waitCnt   = 0;
    while (!cmd_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (load) begin
      e.data  = imm;
      e.carry = 1'b0;
      e.zero  = (imm == 4'd0);
    end else begin
      r       = aluRef(modelRf[rs1], modelRf[rs2], op);
      e.data  = r[3:0];
      e.carry = r[4];
      e.zero  = (r[3:0] == 4'd0);
    end
    e.acceptCyc   = cyc + 1;
    lastAcceptCyc = cyc + 1;
    @(posedge clk);
    if (!load) begin
      expAluA  = modelRf[rs1];
      expAluB  = modelRf[rs2];
      expAluOp = op;
    end
    modelRf[rd] = e.data;
    expQ.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
    @(negedge clk);
  endtask

  task automatic resetModel();
    expQ.delete();
    for (int i = 0; i < 4; i++) modelRf[i] = 4'd0;
    expAluA   = 4'd0;
    expAluB   = 4'd0;
    expAluOp  = 3'd0;
    opsDone   = 0;
    frontSeen = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = 3'd0;
    cmd_rd    = 2'd0;
    cmd_rs1   = 2'd0;
    cmd_rs2   = 2'd0;
    cmd_imm   = 4'd0;
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_data", int'(rsp_data), 0);
    checkOutput("reset_rsp_flags", int'({rsp_carry, rsp_zero}), 0);
    checkOutput("reset_ops_done", int'(ops_done), 0);
    rst       = 1'b0;
    monitorOn = 1;

    // Loads then ADD with carry out: 9 + 8 = 17.
    applyStimulus(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd9);
    applyStimulus(1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd8);
    applyStimulus(0, 3'd0, 2'd3, 2'd1, 2'd2, 4'd0);
    waitDrain();
    checkOutput("add_data", int'(lastData), 1);
    checkOutput("add_carry", int'(lastCarry), 1);
    checkOutput("add_zero", int'(lastZero), 0);
    checkOutput("add_ops_done", int'(ops_done), 3);

    // SUB with borrow, then unsigned SLT.
    applyStimulus(0, 3'd1, 2'd0, 2'd2, 2'd1, 4'd0);
    waitDrain();
    checkOutput("sub_data", int'(lastData), 15);
    checkOutput("sub_carry", int'(lastCarry), 1);
    checkOutput("sub_zero", int'(lastZero), 0);
    applyStimulus(0, 3'd7, 2'd3, 2'd2, 2'd1, 4'd0);
    waitDrain();
    checkOutput("slt_data", int'(lastData), 1);
    checkOutput("slt_carry", int'(lastCarry), 0);

    // Backpressure with a second command waiting the whole time.
    readyLevel = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(0, 3'd2, 2'd0, 2'd1, 2'd2, 4'd0);
    fork
      applyStimulus(0, 3'd3, 2'd1, 2'd1, 2'd2, 4'd0);
      begin
        repeat (6) @(negedge clk);
        readyLevel = 1'b1;
      end
    join
    checkOutput("accept_after_hs", lastAcceptCyc, lastHsCyc + 1);
    waitDrain();
    checkOutput("or_data", int'(lastData), 9);

    // Reset while the command is in EXEC discards everything.
    applyStimulus(0, 3'd0, 2'd0, 2'd1, 2'd2, 4'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_exec_ready", int'(cmd_ready), 1);
    checkOutput("rst_exec_ops", int'(ops_done), 0);
    applyStimulus(0, 3'd0, 2'd0, 2'd1, 2'd2, 4'd0);
    waitDrain();
    checkOutput("post_rst_data", int'(lastData), 0);
    checkOutput("post_rst_zero", int'(lastZero), 1);
    checkOutput("post_rst_ops", int'(ops_done), 1);

    // Same index as destination and source.
    applyStimulus(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3);
    applyStimulus(0, 3'd0, 2'd1, 2'd1, 2'd1, 4'd0);
    waitDrain();
    checkOutput("self_add", int'(lastData), 6);
    applyStimulus(0, 3'd0, 2'd2, 2'd1, 2'd0, 4'd0);
    waitDrain();
    checkOutput("chain_add", int'(lastData), 6);

    // Random traffic up to 256 responses since reset, then wrap check.
    randomReady = 1;
    for (int i = opsDone; i < 256; i++) begin
      applyStimulus(bit'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain();
    checkOutput("ops_wrap", int'(ops_done), 0);

    // Loading zero sets zero and clears carry.
    applyStimulus(1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd0);
    waitDrain();
    checkOutput("load0_data", int'(lastData), 0);
    checkOutput("load0_zero", int'(lastZero), 1);
    checkOutput("load0_carry", int'(lastCarry), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
